// File: rtl/i2s_slave_port.sv
// I2S target endpoint: oversamples external BCLK/LRCLK, deserialises stereo
// ADC words and serialises stereo DAC words through a one-pair pending buffer.
// Build option I2S_UNDERRUN_REPEAT_EN: on DAC underrun repeat the last pair
// instead of sending silence.
`timescale 1ns/1ps
module i2s_slave_port #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata_in,
    output logic                  i2s_sdata_out,
    output logic [DATA_WIDTH-1:0] adc_left_out,
    output logic [DATA_WIDTH-1:0] adc_right_out,
    output logic                  adc_data_valid,
    input  logic [DATA_WIDTH-1:0] dac_left_in,
    input  logic [DATA_WIDTH-1:0] dac_right_in,
    input  logic                  dac_data_valid,
    output logic                  dac_ready,
    output logic                  dac_underrun,
    output logic                  frame_error
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(SLOT_BITS + 1);

    logic [SYNC_STAGES-1:0] bclk_sync_q, lr_sync_q, sdi_sync_q;
    logic                   bclk_last_q;
    logic                   bclk_rise, bclk_fall, lr, sdi;

    logic          lr_prev_q, lr_prev_d, chan_q, chan_d, synced_q, synced_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rx_sr_q, rx_sr_d, left_hold_q, left_hold_d;
    logic          left_ok_q, left_ok_d;
    logic [DW-1:0] adc_l_q, adc_l_d, adc_r_q, adc_r_d;
    logic          adc_vld_q, adc_vld_d, ferr_q, ferr_d, undr_q, undr_d;
    logic [DW-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic          pend_full_q, pend_full_d, ready_q, ready_d;
    logic [DW-1:0] act_l_q, act_l_d, act_r_q, act_r_d, tx_sr_q, tx_sr_d;
    logic          sdo_q, sdo_d;
    logic          boundary, left_start;

    // Input synchronisers plus BCLK edge-detect flop
    always_ff @(posedge clk) begin
        if (rst) begin
            bclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sdi_sync_q  <= '0;
            bclk_last_q <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], i2s_sdata_in};
            bclk_last_q <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign bclk_rise = bclk_sync_q[SYNC_STAGES-1] & ~bclk_last_q;
    assign bclk_fall = ~bclk_sync_q[SYNC_STAGES-1] & bclk_last_q;
    assign lr        = lr_sync_q[SYNC_STAGES-1];
    assign sdi       = sdi_sync_q[SYNC_STAGES-1];

    // Slot tracking, ADC capture, DAC buffering and serialisation
    always_comb begin
        lr_prev_d   = lr_prev_q;
        chan_d      = chan_q;
        synced_d    = synced_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        adc_l_d     = adc_l_q;
        adc_r_d     = adc_r_q;
        adc_vld_d   = 1'b0;
        ferr_d      = 1'b0;
        undr_d      = 1'b0;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pend_full_d = pend_full_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        tx_sr_d     = tx_sr_q;
        sdo_d       = sdo_q;
        boundary    = 1'b0;
        left_start  = 1'b0;

        if (bclk_rise) begin
            lr_prev_d = lr;
            if (lr != lr_prev_q) begin
                boundary = 1'b1;
                cnt_d    = '0;
                chan_d   = lr;
                if (synced_q && (cnt_q < CW'(DW))) begin
                    ferr_d = 1'b1;
                    if (!chan_q) left_ok_d = 1'b0;
                end
                if (!lr) begin
                    left_start = 1'b1;
                    synced_d   = 1'b1;
                    left_ok_d  = 1'b0;
                end
            end else begin
                if (cnt_q != CW'(SLOT_BITS)) cnt_d = cnt_q + CW'(1);
                if (synced_q) begin
                    if (cnt_q < CW'(DW)) rx_sr_d = {rx_sr_q[DW-2:0], sdi};
                    if (cnt_q == CW'(DW - 1)) begin
                        if (!chan_q) begin
                            left_hold_d = rx_sr_d;
                            left_ok_d   = 1'b1;
                        end else if (left_ok_q) begin
                            adc_l_d   = left_hold_q;
                            adc_r_d   = rx_sr_d;
                            adc_vld_d = 1'b1;
                        end
                    end
                    if (cnt_q == CW'(SLOT_BITS - 1)) begin
                        ferr_d    = 1'b1;
                        synced_d  = 1'b0;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end

        if (left_start) begin
            if (pend_full_q) begin
                act_l_d     = pend_l_q;
                act_r_d     = pend_r_q;
                pend_full_d = 1'b0;
            end else begin
                undr_d = 1'b1;
`ifdef I2S_UNDERRUN_REPEAT_EN
                act_l_d = act_l_q;
                act_r_d = act_r_q;
`else
                act_l_d = '0;
                act_r_d = '0;
`endif
            end
        end

        if (boundary) tx_sr_d = lr ? act_r_d : act_l_d;

        if (dac_data_valid && ready_q) begin
            pend_l_d    = dac_left_in;
            pend_r_d    = dac_right_in;
            pend_full_d = 1'b1;
        end
        ready_d = ~pend_full_d;

        if (!synced_q) begin
            sdo_d = 1'b0;
        end else if (bclk_fall) begin
            sdo_d   = tx_sr_q[DW-1];
            tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev_q   <= 1'b0;
            chan_q      <= 1'b0;
            synced_q    <= 1'b0;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            adc_l_q     <= '0;
            adc_r_q     <= '0;
            adc_vld_q   <= 1'b0;
            ferr_q      <= 1'b0;
            undr_q      <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            tx_sr_q     <= '0;
            sdo_q       <= 1'b0;
        end else begin
            lr_prev_q   <= lr_prev_d;
            chan_q      <= chan_d;
            synced_q    <= synced_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            adc_l_q     <= adc_l_d;
            adc_r_q     <= adc_r_d;
            adc_vld_q   <= adc_vld_d;
            ferr_q      <= ferr_d;
            undr_q      <= undr_d;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            tx_sr_q     <= tx_sr_d;
            sdo_q       <= sdo_d;
        end
    end

    assign i2s_sdata_out  = sdo_q;
    assign adc_left_out   = adc_l_q;
    assign adc_right_out  = adc_r_q;
    assign adc_data_valid = adc_vld_q;
    assign dac_ready      = ready_q;
    assign dac_underrun   = undr_q;
    assign frame_error    = ferr_q;
endmodule

// File: tb/tb_i2s_slave_port.sv
// Bench for i2s_slave_port: I2S master BFM (32 BCLK per slot, fclk = 16 x BCLK)
// with an ADC scoreboard checked by a monitor and DAC words checked at the pin.
`timescale 1ns/1ps
module tb_i2s_slave_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata_in, i2s_sdata_out;
    logic [15:0] adc_left_out, adc_right_out, dac_left_in, dac_right_in;
    logic        adc_data_valid, dac_data_valid, dac_ready, dac_underrun, frame_error;

`ifdef I2S_UNDERRUN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    int          ur_cnt = 0;
    logic [31:0] adc_q[$];

    i2s_slave_port dut (
        .clk(clk), .rst(rst),
        .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata_in(i2s_sdata_in),
        .i2s_sdata_out(i2s_sdata_out),
        .adc_left_out(adc_left_out), .adc_right_out(adc_right_out),
        .adc_data_valid(adc_data_valid),
        .dac_left_in(dac_left_in), .dac_right_in(dac_right_in),
        .dac_data_valid(dac_data_valid), .dac_ready(dac_ready),
        .dac_underrun(dac_underrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endfunction

    // Monitor: pops the ADC scoreboard on every valid pulse, tallies event pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (adc_data_valid) begin
                if (adc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL adc_unexpected got %h_%h expected no pulse", adc_left_out, adc_right_out);
                end else begin
                    logic [31:0] e;
                    e = adc_q.pop_front();
                    check("adc_left", 32'(adc_left_out), 32'(e[31:16]));
                    check("adc_right", 32'(adc_right_out), 32'(e[15:0]));
                end
            end
            if (frame_error) fe_cnt++;
            if (dac_underrun) ur_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    // One LR half-frame of nbits BCLK periods; captures DUT output at each rise
    task automatic do_slot(input logic lr_v, input logic [15:0] word, input int nbits,
                           input logic chk, input logic [15:0] exp_tx, input string name);
        logic [63:0] cap;
        logic [15:0] got;
        cap = '0;
        for (int k = 0; k < nbits; k++) begin
            i2s_bclk     = 1'b0;
            i2s_lrclk    = lr_v;
            i2s_sdata_in = (k >= 1 && k <= 16) ? word[16-k] : 1'b0;
            #80;
            cap[k]   = i2s_sdata_out;
            i2s_bclk = 1'b1;
            #80;
        end
        for (int k = 1; k <= 16; k++) got[16-k] = cap[k];
        if (chk) begin
            check(name, 32'(got), 32'(exp_tx));
            if (nbits >= 32) check({name, "_tail"}, 32'(cap[31:17]), 32'd0);
        end
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        check("offer_ready", 32'(dac_ready), 32'd1);
        dac_left_in    = l;
        dac_right_in   = r;
        dac_data_valid = 1'b1;
        @(negedge clk);
        dac_data_valid = 1'b0;
        check("accept_ready_low", 32'(dac_ready), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        i2s_bclk = 1'b1;
        i2s_lrclk = 1'b0;
        i2s_sdata_in = 1'b0;
        dac_left_in = '0;
        dac_right_in = '0;
        dac_data_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_flags", {27'd0, i2s_sdata_out, adc_data_valid, dac_ready, dac_underrun, frame_error}, 32'd0);
        check("rst_adc", {adc_left_out, adc_right_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(dac_ready), 32'd1);

        // Unsynced lead-in right slot, then frame 1 with an offered pair
        offer(16'hC003, 16'h0FF0);
        do_slot(1'b1, 16'hFFFF, 32, 1'b1, 16'h0000, "lead_in_tx");
        check("ready_pending", 32'(dac_ready), 32'd0);
        adc_q.push_back({16'hA55A, 16'h1234});
        do_slot(1'b0, 16'hA55A, 32, 1'b1, 16'hC003, "f1_left_tx");
        check("ready_after_f1", 32'(dac_ready), 32'd1);
        do_slot(1'b1, 16'h1234, 32, 1'b1, 16'h0FF0, "f1_right_tx");
        check("ur_f1", 32'(ur_cnt), 32'd0);

        // Frame 2: underrun
        adc_q.push_back({16'h8001, 16'h7FFE});
        do_slot(1'b0, 16'h8001, 32, 1'b1, REP ? 16'hC003 : 16'h0000, "f2_left_tx");
        check("ur_f2", 32'(ur_cnt), 32'd1);
        do_slot(1'b1, 16'h7FFE, 32, 1'b1, REP ? 16'h0FF0 : 16'h0000, "f2_right_tx");

        // Frame 3: truncated left slot
        offer(16'h5A5A, 16'hF00F);
        do_slot(1'b0, 16'hDEAD, 10, 1'b0, 16'h0000, "");
        do_slot(1'b1, 16'hBEEF, 32, 1'b1, 16'hF00F, "f3_right_tx");
        check("fe_short", 32'(fe_cnt), 32'd1);

        // Frame 4: recovers normally, underrun again
        adc_q.push_back({16'h0F0F, 16'hF0F0});
        do_slot(1'b0, 16'h0F0F, 32, 1'b1, REP ? 16'h5A5A : 16'h0000, "f4_left_tx");
        do_slot(1'b1, 16'hF0F0, 32, 1'b1, REP ? 16'hF00F : 16'h0000, "f4_right_tx");
        check("ur_f4", 32'(ur_cnt), 32'd2);

        // Frame 5: reset in the middle of the right slot
        do_slot(1'b0, 16'h4444, 32, 1'b1, REP ? 16'h5A5A : 16'h0000, "f5_left_tx");
        do_slot(1'b1, 16'h5555, 8, 1'b0, 16'h0000, "");
        check("ur_f5", 32'(ur_cnt), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_adc", {adc_left_out, adc_right_out}, 32'd0);
        check("midrst_flags", {29'd0, i2s_sdata_out, dac_ready, adc_data_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_midrst", 32'(dac_ready), 32'd1);
        do_slot(1'b1, 16'h6666, 24, 1'b1, 16'h0000, "post_rst_tx");

        // Frame 6: re-sync on the 1->0 edge
        offer(16'h0001, 16'h8000);
        adc_q.push_back({16'h1357, 16'h2468});
        do_slot(1'b0, 16'h1357, 32, 1'b1, 16'h0001, "f6_left_tx");
        do_slot(1'b1, 16'h2468, 32, 1'b1, 16'h8000, "f6_right_tx");
        check("ur_f6", 32'(ur_cnt), 32'd3);

        // Frame 7: overlong left slot drops sync
        do_slot(1'b0, 16'h9999, 40, 1'b1, REP ? 16'h0001 : 16'h0000, "f7_left_tx");
        check("fe_long", 32'(fe_cnt), 32'd2);
        do_slot(1'b1, 16'hAAAA, 32, 1'b1, 16'h0000, "f7_right_tx");

        // Frame 8: re-sync and normal capture
        offer(16'h1248, 16'h8421);
        adc_q.push_back({16'hC3C3, 16'h3C3C});
        do_slot(1'b0, 16'hC3C3, 32, 1'b1, 16'h1248, "f8_left_tx");
        do_slot(1'b1, 16'h3C3C, 32, 1'b1, 16'h8421, "f8_right_tx");

        repeat (20) @(negedge clk);
        check("adc_missing", 32'(adc_q.size()), 32'd0);
        check("fe_total", 32'(fe_cnt), 32'd2);
        check("ur_total", 32'(ur_cnt), 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
